mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Sequencer and HI/LO owner for the multi-cycle MULT_DIV unit in the EX stage.
//  Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo requests from EX, pulses the unit's enable, and tracks its in_operation.
//  Captures the 64-bit product or quotient/remainder into HI/LO and stalls the pipeline while HI/LO is not yet valid.
// PARAMETERS
//  MAX_CYCLES  64  BUSY-state watchdog limit in cycles; on expiry the op is abandoned and err_o is set
//  CNT_W       7   cycle-counter width; must satisfy 2**CNT_W > MAX_CYCLES
// PORTS
//  clk          in   1   rising-edge clock; the only clock
//  rst_n        in   1   asynchronous, active-low reset
//  issue_valid  in   1   request present; requester holds it stable until accepted (issue_valid & !stall_o)
//  issue_op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO
//  rs_val       in   32  operand 1 (dividend/multiplicand; source for MTHI/MTLO)
//  rt_val       in   32  operand 2 (divisor/multiplier)
//  flush        in   1   squash the in-flight mult/div; its result is discarded
//  stall_o      out  1   combinational: issue_valid & (state != IDLE)
//  rd_data      out  32  MFHI/MFLO read data
//  rd_valid     out  1   one-cycle pulse qualifying rd_data
//  err_o        out  1   sticky watchdog flag; cleared only by reset
//  md_enable    out  1   MULT_DIV enable, one-cycle pulse
//  md_operation out  2   {is_div, is_signed}: MULT 01, MULTU 00, DIV 11, DIVU 10
//  md_value_1   out  32  latched rs_val
//  md_value_2   out  32  latched rt_val
//  md_out       in   64  MULT_DIV result {hi,lo}
//  md_in_op     in   1   MULT_DIV in_operation
// BEHAVIOUR
//  Reset (async, rst_n=0): state=DRAIN; hi=lo=0; rd_data=0; rd_valid=0; err_o=0; md_enable=0; md_operation=0;
//   md_value_1/2=0; cnt=0; discard=0. MULT_DIV has no reset, so reset mid-operation is handled via DRAIN.
//  States:
//   DRAIN: wait while md_in_op=1; go IDLE on md_in_op=0. No request is accepted in DRAIN.
//   IDLE: on an accepted issue:
//    - op 0-3: latch operands and md_operation; md_enable=1 for exactly one cycle; cnt=0; go START.
//    - op 4/5: rd_data<=hi/lo and rd_valid=1 on the next edge (latency 1). Stay IDLE.
//    - op 6/7: hi/lo<=rs_val on the next edge; a read issued the following cycle returns the new value.
//   START: wait for md_in_op=1, then go BUSY. If md_in_op is still 0 after 2 cycles, treat as complete and go DONE.
//   BUSY: cnt++ each cycle. On md_in_op=0 (falling edge) go DONE.
//    If cnt reaches MAX_CYCLES: err_o<=1; hi/lo unchanged; go DRAIN.
//   DONE: if discard=0, {hi,lo}<=md_out; clear discard; go IDLE. Total stall = unit latency + 2 cycles.
//  flush in START/BUSY: discard<=1. The FSM still waits for the unit, so stall_o semantics are unchanged.
//   flush in IDLE or DRAIN: no effect.
//  Any issue while state != IDLE -> stall_o=1 and the request is not consumed, including MFHI/MFLO/MTHI/MTLO.
//  Simultaneous flush and accepted issue in IDLE: the issue proceeds; flush only affects an op already in flight.
//  rd_valid is deasserted every cycle it is not explicitly pulsed. md_enable is never high outside the IDLE->START edge.
//  Operands are passed to the unit unmodified; signedness is conveyed only by md_operation[0].
// CONFIGURATION
//  MDU_ZERO_DIV_EN defined: DIV/DIVU with rt_val==0 does not enable the unit.
//   Next edge: hi<=rs_val, lo<=32'hFFFF_FFFF; state stays IDLE; stall_o stays 0 (1-cycle op).
//  MDU_ZERO_DIV_EN undefined: divide-by-zero goes to the unit like any other op; HI/LO take whatever md_out returns.
// TESTING
//  1 MULT rs=7 rt=-3, model unit latency 5 -> md_operation=01, single md_enable pulse; hi=FFFFFFFF, lo=FFFFFFEB; stall_o covers 7 cycles.
//  2 MTHI rs=0x1234, then MFHI next cycle -> rd_valid pulse with rd_data=0x1234, one cycle after the MFHI issue.
//  3 DIVU 100/7 with flush during BUSY, then MFLO -> rd_data = pre-op lo; unit still drained before MFLO is accepted.
//  4 MFLO issued while BUSY -> stall_o=1 until DONE, then rd_data = new lo.
//  5 rst_n low mid-BUSY with md_in_op held high 3 more cycles -> DRAIN, all requests stalled until md_in_op=0; hi=lo=0.
//  6 Unit holds md_in_op=1 for 70 cycles -> err_o=1 at cycle MAX_CYCLES; hi/lo unchanged;
//    with MDU_ZERO_DIV_EN, DIV 5/0 -> hi=5, lo=FFFFFFFF, no md_enable.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Sequencer and HI/LO owner for the multi-cycle MULT_DIV unit in the EX stage.
// Optional feature: define MDU_ZERO_DIV_EN to resolve divide-by-zero locally without the unit.
module mdu_ctrl #(
    parameter int unsigned MAX_CYCLES = 64,
    parameter int unsigned CNT_W      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        stall_o,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        err_o,
    output logic        md_enable,
    output logic [1:0]  md_operation,
    output logic [31:0] md_value_1,
    output logic [31:0] md_value_2,
    input  logic [63:0] md_out,
    input  logic        md_in_op
);

    typedef enum logic [2:0] {
        StDrain,
        StIdle,
        StStart,
        StBusy,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               err_q, err_d;
    logic               md_enable_q, md_enable_d;
    logic [1:0]         md_operation_q, md_operation_d;
    logic [31:0]        md_value_1_q, md_value_1_d;
    logic [31:0]        md_value_2_q, md_value_2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               discard_q, discard_d;
    logic               zero_div;

`ifdef MDU_ZERO_DIV_EN
    assign zero_div = issue_op[1] & (rt_val == 32'd0);
`else
    assign zero_div = 1'b0;
`endif

    assign stall_o      = issue_valid & (state_q != StIdle);
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign err_o        = err_q;
    assign md_enable    = md_enable_q;
    assign md_operation = md_operation_q;
    assign md_value_1   = md_value_1_q;
    assign md_value_2   = md_value_2_q;

    always_comb begin
        state_d        = state_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        rd_data_d      = rd_data_q;
        rd_valid_d     = 1'b0;
        err_d          = err_q;
        md_enable_d    = 1'b0;
        md_operation_d = md_operation_q;
        md_value_1_d   = md_value_1_q;
        md_value_2_d   = md_value_2_q;
        cnt_d          = cnt_q;
        discard_d      = discard_q;

        unique case (state_q)
            StDrain: begin
                // The unit has no reset; never issue while it may still be running.
                if (!md_in_op) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (issue_valid) begin
                    if (!issue_op[2]) begin
                        if (zero_div) begin
                            hi_d = rs_val;
                            lo_d = 32'hFFFF_FFFF;
                        end else begin
                            md_value_1_d   = rs_val;
                            md_value_2_d   = rt_val;
                            md_operation_d = {issue_op[1], ~issue_op[0]};
                            md_enable_d    = 1'b1;
                            cnt_d          = '0;
                            state_d        = StStart;
                        end
                    end else begin
                        unique case (issue_op[1:0])
                            2'd0: begin
                                rd_data_d  = hi_q;
                                rd_valid_d = 1'b1;
                            end
                            2'd1: begin
                                rd_data_d  = lo_q;
                                rd_valid_d = 1'b1;
                            end
                            2'd2: hi_d = rs_val;
                            2'd3: lo_d = rs_val;
                            default: ;
                        endcase
                    end
                end
            end
            StStart: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (md_in_op) begin
                    cnt_d   = '0;
                    state_d = StBusy;
                end else if (cnt_q == CNT_W'(1)) begin
                    // Unit never reported busy: its result is already on md_out.
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StBusy: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (!md_in_op) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(MAX_CYCLES)) begin
                        err_d     = 1'b1;
                        discard_d = 1'b0;
                        state_d   = StDrain;
                    end
                end
            end
            StDone: begin
                if (!discard_q) begin
                    {hi_d, lo_d} = md_out;
                end
                discard_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StDrain;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StDrain;
            hi_q           <= '0;
            lo_q           <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            err_q          <= 1'b0;
            md_enable_q    <= 1'b0;
            md_operation_q <= '0;
            md_value_1_q   <= '0;
            md_value_2_q   <= '0;
            cnt_q          <= '0;
            discard_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            err_q          <= err_d;
            md_enable_q    <= md_enable_d;
            md_operation_q <= md_operation_d;
            md_value_1_q   <= md_value_1_d;
            md_value_2_q   <= md_value_2_d;
            cnt_q          <= cnt_d;
            discard_q      <= discard_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: behavioural MULT_DIV model plus a read-data scoreboard.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        stall_o;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err_o;
    logic        md_enable;
    logic [1:0]  md_operation;
    logic [31:0] md_value_1;
    logic [31:0] md_value_2;
    logic [63:0] md_out = '0;
    logic        md_in_op;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_exp;

    int unsigned lat = 5;
    int          rem_cyc = 0;
    logic [63:0] pend = '0;

    int          en_cnt = 0;
    int          en_run = 0;
    int          en_max_run = 0;
    logic [1:0]  cap_op;
    logic [31:0] cap_v1;
    logic [31:0] cap_v2;

    mdu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_op     (issue_op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .flush        (flush),
        .stall_o      (stall_o),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .err_o        (err_o),
        .md_enable    (md_enable),
        .md_operation (md_operation),
        .md_value_1   (md_value_1),
        .md_value_2   (md_value_2),
        .md_out       (md_out),
        .md_in_op     (md_in_op)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] unit_fn(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b01: return sa * sb;
            2'b00: return {32'd0, a} * {32'd0, b};
            2'b11: begin
                if (b == 32'd0) return 64'h0000_DEAD_0000_BEEF;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return 64'h0000_DEAD_0000_BEEF;
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Unit model: busy for lat-1 cycles after the enable edge, result valid when it drops.
    always @(posedge clk) begin
        if (md_enable) begin
            rem_cyc <= int'(lat) - 1;
            pend    <= unit_fn(md_operation, md_value_1, md_value_2);
            md_out  <= 64'hBADC_0FFE_E0DD_F00D;
        end else if (rem_cyc > 0) begin
            rem_cyc <= rem_cyc - 1;
            if (rem_cyc == 1) md_out <= pend;
        end
    end
    assign md_in_op = (rem_cyc > 0);

    always @(negedge clk) begin
        if (md_enable) begin
            en_cnt <= en_cnt + 1;
            en_run <= en_run + 1;
            if (en_run + 1 > en_max_run) en_max_run <= en_run + 1;
            cap_op <= md_operation;
            cap_v1 <= md_value_1;
            cap_v2 <= md_value_2;
        end else begin
            en_run <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_spurious", 64'(rd_valid), 64'd0);
            end else begin
                rd_exp = exp_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(rd_exp));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic do_issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            output int stalls);
        int n;
        n           = 0;
        issue_valid = 1'b1;
        issue_op    = op;
        rs_val      = rs;
        rt_val      = rt;
        @(negedge clk);
        while (stall_o && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (stall_o) check("issue_accept_timeout", 64'(stall_o), 64'd0);
        stalls = n;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic do_read(input logic sel_hi, input logic [31:0] exp, output int stalls);
        exp_q.push_back(exp);
        do_issue(sel_hi ? 3'd4 : 3'd5, 32'd0, 32'd0, stalls);
        @(negedge clk);
        check("rd_valid_latency", 64'(rd_valid), 64'd1);
        @(negedge clk);
        check("rd_valid_pulse", 64'(rd_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int n;
        int en0;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_op    = '0;
        rs_val      = '0;
        rt_val      = '0;
        flush       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        issue_valid = 1'b1;
        #1;
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_md_enable", 64'(md_enable), 64'd0);
        check("rst_md_operation", 64'(md_operation), 64'd0);
        check("rst_md_values", {md_value_1, md_value_2}, 64'd0);
        check("rst_stall_drain", 64'(stall_o), 64'd1);
        issue_valid = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
        do_read(1'b1, 32'd0, st);
        do_read(1'b0, 32'd0, st);

        // MULT 7 * -3, unit latency 5
        en0 = en_cnt;
        do_issue(3'd0, 32'd7, 32'hFFFF_FFFD, st);
        do_read(1'b0, 32'hFFFF_FFEB, st);
        check("mult_stall_cycles", 64'(st), 64'd7);
        check("mult_en_count", 64'(en_cnt - en0), 64'd1);
        check("mult_md_op", 64'(cap_op), 64'b01);
        check("mult_operands", {cap_v1, cap_v2}, {32'd7, 32'hFFFF_FFFD});
        do_read(1'b1, 32'hFFFF_FFFF, st);

        // MTHI then MFHI the next cycle
        do_issue(3'd6, 32'h0000_1234, 32'd0, st);
        do_read(1'b1, 32'h0000_1234, st);
        check("mfhi_no_stall", 64'(st), 64'd0);

        // MULTU with full-width operand
        do_issue(3'd1, 32'hFFFF_FFFF, 32'd2, st);
        check("multu_md_op_pending", 64'(md_operation), 64'b00);
        do_read(1'b1, 32'h0000_0001, st);
        do_read(1'b0, 32'hFFFF_FFFE, st);

        // DIVU 100/7, MFLO issued while busy
        lat = 8;
        do_issue(3'd3, 32'd100, 32'd7, st);
        do_read(1'b0, 32'd14, st);
        check("divu_read_stalled", 64'(st), 64'd10);
        check("divu_md_op", 64'(cap_op), 64'b10);
        do_read(1'b1, 32'd2, st);

        // DIV -100/7 signed
        do_issue(3'd2, 32'hFFFF_FF9C, 32'd7, st);
        do_read(1'b0, 32'hFFFF_FFF2, st);
        do_read(1'b1, 32'hFFFF_FFFE, st);
        check("div_md_op", 64'(cap_op), 64'b11);
        check("div_operands", {cap_v1, cap_v2}, {32'hFFFF_FF9C, 32'd7});

        // Flushed DIVU: result discarded but unit still drained
        lat = 10;
        do_issue(3'd7, 32'hAAAA_5555, 32'd0, st);
        do_issue(3'd3, 32'd100, 32'd7, st);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        do_read(1'b0, 32'hAAAA_5555, st);
        check("flush_drain_stall", 64'(st), 64'd8);
        do_read(1'b1, 32'hFFFF_FFFE, st);

        // Flush coincident with an accepted issue does not cancel it
        lat   = 5;
        flush = 1'b1;
        do_issue(3'd0, 32'd2, 32'd3, st);
        flush = 1'b0;
        do_read(1'b0, 32'd6, st);
        do_read(1'b1, 32'd0, st);

        // Reset mid-BUSY: unit keeps running, controller drains first
        lat = 7;
        do_issue(3'd0, 32'd5, 32'd6, st);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy_in_op", 64'(md_in_op), 64'd1);
        check("rst_mid_err", 64'(err_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_read(1'b1, 32'd0, st);
        check("drain_stall_cycles", 64'(st), 64'd4);
        do_read(1'b0, 32'd0, st);

        // Divide by zero
        lat = 5;
        en0 = en_cnt;
`ifdef MDU_ZERO_DIV_EN
        do_issue(3'd2, 32'd5, 32'd0, st);
        do_read(1'b1, 32'd5, st);
        check("zdiv_no_stall", 64'(st), 64'd0);
        do_read(1'b0, 32'hFFFF_FFFF, st);
        check("zdiv_no_enable", 64'(en_cnt - en0), 64'd0);
`else
        do_issue(3'd3, 32'd5, 32'd0, st);
        do_read(1'b1, 32'h0000_DEAD, st);
        do_read(1'b0, 32'h0000_BEEF, st);
        check("zdiv_enable", 64'(en_cnt - en0), 64'd1);
`endif

        // Watchdog: unit stuck for 70 cycles
        do_issue(3'd6, 32'h1111_1111, 32'd0, st);
        do_issue(3'd7, 32'h2222_2222, 32'd0, st);
        lat = 70;
        do_issue(3'd0, 32'd3, 32'd4, st);
        n = 0;
        @(negedge clk);
        while (!err_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("wdog_window", 64'((n >= 64) && (n <= 68)), 64'd1);
        @(posedge clk);
        #1;
        do_read(1'b1, 32'h1111_1111, st);
        check("wdog_drained_before_read", 64'(st > 0), 64'd1);
        do_read(1'b0, 32'h2222_2222, st);
        check("err_sticky", 64'(err_o), 64'd1);

        check("en_single_cycle", 64'(en_max_run), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
